// File: rtl/pe_pkg.sv
// Shared PE definitions: partial-sum type, accumulator states and saturation limits.
package pe_pkg;

  localparam int PSUM_W = 24;

  typedef logic signed [PSUM_W-1:0] psum_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } acc_state_e;

  localparam psum_t PSUM_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
  localparam psum_t PSUM_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

endpackage

// File: rtl/pe_fifo2.sv
// Two-entry in-order FIFO; the head entry is presented combinationally on pop_data.
module pe_fifo2
  import pe_pkg::*;
#(
  parameter int DW = PSUM_W + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == 2'd0);
  assign full     = (count == 2'd2);
  assign do_pop   = pop && !empty;
  // When full, the slot being written is the one popped this same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pe_psum_acc.sv
// Partial-sum accumulator: sums cfg_len signed terms with saturation and queues
// each result (with its sticky overflow flag) in a 2-entry output FIFO.
module pe_psum_acc
  import pe_pkg::*;
#(
  parameter int W     = PSUM_W,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic [CNT_W-1:0]    cfg_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data,
  output logic                out_ovf,
  output logic                busy
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Returns {clamped, value}; overflow shows as disagreeing top two sum bits.
  function automatic logic [W:0] sat_sum(input logic signed [W:0] s);
    logic [W:0] r;
    if (s[W] != s[W-1]) r = {1'b1, s[W], {(W-1){~s[W]}}};
    else                r = {1'b0, s[W-1:0]};
    return r;
  endfunction

  acc_state_e          state, state_nxt;
  logic signed [W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0]    len, len_nxt, len_sel;
  logic                ovf, ovf_nxt;
  logic signed [W:0]   sum;
  logic [W:0]          sat_res;
  logic                beat;
  logic                push;
  logic                fifo_full;
  logic                fifo_empty;
  logic [W:0]          head;

  assign in_ready = !fifo_full && !clear;
  assign beat     = in_valid && in_ready;
  assign busy     = (state == ST_ACC);
  assign cnt_inc  = cnt + ONE;
  assign sum      = $signed({acc[W-1], acc}) + $signed({in_data[W-1], in_data});
  assign sat_res  = sat_sum(sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      len   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      len   <= len_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    len_nxt   = len;
    ovf_nxt   = ovf;
    len_sel   = (cfg_len == '0) ? ONE : cfg_len;
    push      = 1'b0;
    if (clear) begin
      state_nxt = ST_IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else if (beat) begin
      case (state)
        ST_IDLE: begin
          len_nxt = len_sel;
          acc_nxt = in_data;
          cnt_nxt = ONE;
          ovf_nxt = 1'b0;
          if (len_sel > ONE) state_nxt = ST_ACC;
          else               push      = 1'b1;
        end
        ST_ACC: begin
          acc_nxt = sat_res[W-1:0];
          ovf_nxt = ovf | sat_res[W];
          cnt_nxt = cnt_inc;
          if (cnt_inc == len) begin
            push      = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  pe_fifo2 #(.DW(W + 1)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({ovf_nxt, acc_nxt}),
    .pop       (out_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? $signed(head[W-1:0]) : '0;
  assign out_ovf   = out_valid & head[W];

endmodule

// File: tb/tb_pe_psum_acc.sv
// Scoreboard bench for pe_psum_acc: expected {ovf,data} queued at stimulus time,
// compared whenever the DUT hands off a result.
`timescale 1ns/100ps
module tb_pe_psum_acc;
  import pe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [7:0]  cfg_len;
  logic        in_valid;
  logic        in_ready;
  psum_t       in_data;
  logic        out_valid;
  logic        out_ready;
  psum_t       out_data;
  logic        out_ovf;
  logic        busy;

  logic [24:0] exp_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  pe_psum_acc #(.W(24), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic send(input logic [23:0] d);
    int waited = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while ((exp_q.size() != 0 || out_valid) && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    #1;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Output hand-offs are sampled mid-cycle; the transfer completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("out_unexpected", 32'(out_valid), 32'd0);
      else chk("out", 32'({out_ovf, out_data}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; cfg_len = 8'd1; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out", 32'({out_ovf, out_data}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Four-term sum with latency-1 output
    cfg_len = 8'd4;
    exp_q.push_back({1'b0, 24'd10});
    send(24'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    send(24'd2);
    send(24'd3);
    chk("t1_no_early_out", 32'(out_valid), 32'd0);
    send(24'd4);
    chk("t1_lat_valid", 32'(out_valid), 32'd1);
    chk("t1_lat_data", 32'(out_data), 32'd10);
    chk("t1_idle", 32'(busy), 32'd0);
    drain();

    // Positive and negative saturation
    cfg_len = 8'd2;
    exp_q.push_back({1'b1, PSUM_MAX});
    exp_q.push_back({1'b1, PSUM_MIN});
    send(24'h7FFFFF);
    send(24'h000001);
    send(24'h800000);
    send(24'hFFFFFF);
    drain();

    // Backpressure: FIFO fills, third term stalls
    cfg_len = 8'd1;
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 24'd5});
    exp_q.push_back({1'b0, 24'd6});
    exp_q.push_back({1'b0, 24'd7});
    send(24'd5);
    send(24'd6);
    chk("t3_full_ready", 32'(in_ready), 32'd0);
    fork
      send(24'd7);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("t3_stall_ready", 32'(in_ready), 32'd0);
        chk("t3_head", 32'(out_data), 32'd5);
        chk("t3_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
      end
    join
    drain();

    // Clear aborts a partial accumulation
    cfg_len = 8'd3;
    exp_q.push_back({1'b0, 24'd6});
    send(24'd1);
    send(24'd1);
    chk("t4_busy", 32'(busy), 32'd1);
    clear = 1'b1;
    #1;
    chk("t4_clear_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("t4_after_clear", 32'(busy), 32'd0);
    send(24'd2);
    send(24'd2);
    send(24'd2);
    drain();

    // Asynchronous reset mid-accumulation with a result held in the FIFO
    out_ready = 1'b0;
    cfg_len = 8'd1;
    send(24'd4);
    cfg_len = 8'd3;
    send(24'd3);
    send(24'd3);
    chk("t5_pre_busy", 32'(busy), 32'd1);
    chk("t5_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #0.5;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_data", 32'(out_data), 32'd0);
    chk("t5_rst_ready", 32'(in_ready), 32'd1);
    #0.5;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_ghost", 32'(out_valid), 32'd0);
    exp_q.push_back({1'b0, 24'd9});
    send(24'd3);
    send(24'd3);
    send(24'd3);
    drain();

    // Pop and final-beat push in the same cycle with one entry held
    out_ready = 1'b0;
    cfg_len = 8'd1;
    exp_q.push_back({1'b0, 24'd11});
    exp_q.push_back({1'b0, 24'd41});
    send(24'd11);
    cfg_len = 8'd2;
    send(24'd20);
    out_ready = 1'b1;
    send(24'd21);
    chk("t6_valid", 32'(out_valid), 32'd1);
    chk("t6_not_full", 32'(in_ready), 32'd1);
    chk("t6_head", 32'(out_data), 32'd41);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
